// File: rtl/smaesh_word_bridge_pkg.sv
// Shared constants for the SMAESH word bridge: opcodes, header layout, FSM encoding.
package smaesh_word_bridge_pkg;

  localparam logic [1:0] OP_ENCRYPT = 2'd0;
  localparam logic [1:0] OP_RESEED  = 2'd1;

  localparam int HDR_OP_LSB    = 0;
  localparam int HDR_OP_W      = 2;
  localparam int HDR_REUSE_BIT = 2;

  localparam int WORD_W     = 32;
  localparam int BLOCK_W    = 128;
  localparam int SEED_W     = 80;
  localparam int SEED_WORDS = 3;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_LD_PT,
    ST_LD_KEY,
    ST_LD_SEED,
    ST_ISSUE,
    ST_ISSUE_SEED
  } state_t;

endpackage

// File: rtl/smaesh_word_bridge_if.sv
// Host word streams and masked-core block handshakes of the SMAESH word bridge.
interface smaesh_word_bridge_if #(parameter int d = 2);
  import smaesh_word_bridge_pkg::*;

  logic                   in_word_valid;
  logic                   in_word_ready;
  logic [WORD_W-1:0]      in_word;
  logic                   out_word_valid;
  logic                   out_word_ready;
  logic [WORD_W-1:0]      out_word;
  logic                   core_in_valid;
  logic                   core_in_ready;
  logic [BLOCK_W*d-1:0]   core_plaintext;
  logic [BLOCK_W*d-1:0]   core_key;
  logic                   core_seed_valid;
  logic                   core_seed_ready;
  logic [SEED_W-1:0]      core_seed;
  logic                   core_ct_valid;
  logic                   core_ct_ready;
  logic [BLOCK_W*d-1:0]   core_ct;
  logic                   err;

  modport master (
    input  in_word_valid, in_word, out_word_ready, core_in_ready, core_seed_ready,
    input  core_ct_valid, core_ct,
    output in_word_ready, out_word_valid, out_word, core_in_valid, core_plaintext,
    output core_key, core_seed_valid, core_seed, core_ct_ready, err
  );

  modport slave (
    output in_word_valid, in_word, out_word_ready, core_in_ready, core_seed_ready,
    output core_ct_valid, core_ct,
    input  in_word_ready, out_word_valid, out_word, core_in_valid, core_plaintext,
    input  core_key, core_seed_valid, core_seed, core_ct_ready, err
  );

endinterface

// File: rtl/smaesh_word_ser.sv
// One-block ciphertext buffer that streams the captured block out as words, word 0 first.
module smaesh_word_ser #(
  parameter int N_WORDS = 8,
  parameter int WORD_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_WORDS*WORD_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_data
);

  localparam int IW = $clog2(N_WORDS);
  localparam logic [IW-1:0] LAST = IW'(N_WORDS - 1);

  logic                      full_q;
  logic [IW-1:0]             idx_q;
  logic [N_WORDS*WORD_W-1:0] buf_q;

  // ready comes from the registered flag, so a drained buffer shows one empty cycle before refilling
  assign in_ready  = ~full_q;
  assign out_valid = full_q & ~rst;
  assign out_data  = buf_q[WORD_W*idx_q +: WORD_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      idx_q  <= '0;
    end else if (!full_q) begin
      if (in_valid) begin
        full_q <= 1'b1;
        idx_q  <= '0;
      end
    end else if (out_ready) begin
      if (idx_q == LAST) begin
        full_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && !full_q) buf_q <= in_data;
  end

endmodule

// File: rtl/smaesh_word_bridge.sv
// Word-stream front end for a masked AES core: loads plaintext/key/seed, serialises ciphertext.
// Build option SMAESH_KEY_CACHE_EN: encrypt headers with reuse_key set skip the key load.
module smaesh_word_bridge
  import smaesh_word_bridge_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  smaesh_word_bridge_if.master bus
);

  localparam int N_WORDS = 4 * d;
  localparam int CW      = $clog2(N_WORDS);
  localparam int BW      = BLOCK_W * d;
  localparam logic [CW-1:0] LAST_WORD = CW'(N_WORDS - 1);
  localparam logic [CW-1:0] SEED_LAST = CW'(SEED_WORDS - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     pt_q, key_q;
  logic [SEED_W-1:0] seed_q;
  logic              err_q;
  logic              loading, in_fire, last_word;
  logic [1:0]        hdr_op;
`ifdef SMAESH_KEY_CACHE_EN
  logic              reuse_q;
`endif

  assign hdr_op    = bus.in_word[HDR_OP_LSB +: HDR_OP_W];
  assign loading   = state_q inside {ST_HDR, ST_LD_PT, ST_LD_KEY, ST_LD_SEED};
  assign in_fire   = bus.in_word_valid & bus.in_word_ready;
  assign last_word = (cnt_q == LAST_WORD);

  assign bus.in_word_ready   = ~rst & loading;
  assign bus.core_in_valid   = ~rst & (state_q == ST_ISSUE);
  assign bus.core_seed_valid = ~rst & (state_q == ST_ISSUE_SEED);
  assign bus.core_plaintext  = pt_q;
  assign bus.core_key        = key_q;
  assign bus.core_seed       = seed_q;
  assign bus.err             = ~rst & err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR: begin
        if (in_fire) begin
          if (hdr_op == OP_ENCRYPT)     state_d = ST_LD_PT;
          else if (hdr_op == OP_RESEED) state_d = ST_LD_SEED;
        end
      end
      ST_LD_PT: begin
        if (in_fire && last_word) begin
`ifdef SMAESH_KEY_CACHE_EN
          state_d = reuse_q ? ST_ISSUE : ST_LD_KEY;
`else
          state_d = ST_LD_KEY;
`endif
        end
      end
      ST_LD_KEY:     if (in_fire && last_word) state_d = ST_ISSUE;
      ST_LD_SEED:    if (in_fire && (cnt_q == SEED_LAST)) state_d = ST_ISSUE_SEED;
      ST_ISSUE:      if (bus.core_in_ready) state_d = ST_HDR;
      ST_ISSUE_SEED: if (bus.core_seed_ready) state_d = ST_HDR;
      default:       state_d = ST_HDR;
    endcase
  end

  // an invalid header leaves the FSM in HDR, so the counter only advances in load states
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HDR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= in_fire && (state_q == ST_HDR) &&
                 (hdr_op != OP_ENCRYPT) && (hdr_op != OP_RESEED);
      if (state_d != state_q)                    cnt_q <= '0;
      else if (in_fire && (state_q != ST_HDR)) cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      case (state_q)
`ifdef SMAESH_KEY_CACHE_EN
        ST_HDR:     reuse_q <= bus.in_word[HDR_REUSE_BIT];
`endif
        ST_LD_PT:   pt_q[WORD_W*cnt_q +: WORD_W]  <= bus.in_word;
        ST_LD_KEY:  key_q[WORD_W*cnt_q +: WORD_W] <= bus.in_word;
        ST_LD_SEED: begin
          if (cnt_q == CW'(0))      seed_q[31:0]  <= bus.in_word;
          else if (cnt_q == CW'(1)) seed_q[63:32] <= bus.in_word;
          else                      seed_q[79:64] <= bus.in_word[15:0];
        end
        default: ;
      endcase
    end
  end

  smaesh_word_ser #(
    .N_WORDS (N_WORDS),
    .WORD_W  (WORD_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.core_ct_valid),
    .in_ready  (bus.core_ct_ready),
    .in_data   (bus.core_ct),
    .out_valid (bus.out_word_valid),
    .out_ready (bus.out_word_ready),
    .out_data  (bus.out_word)
  );

endmodule

// File: tb/tb_smaesh_word_bridge.sv
// Self-checking bench for smaesh_word_bridge (d=2): encrypt table, reseed, errors, ciphertext scoreboard, reset.
module tb_smaesh_word_bridge;
  localparam int D = 2;

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] base;
    logic [31:0] stride;
  } enc_vec_t;

  localparam logic [255:0] CT1 =
    256'h01234567_89ABCDEF_00112233_44556677_8899AABB_CCDDEEFF_DEADBEEF_CAFEF00D;
  localparam logic [255:0] CT2 =
    256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;

  logic clk = 1'b0;
  logic rst;
  int n_pass  = 0;
  int n_total = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  mon_exp;
  logic [255:0] last_key;
  logic [31:0]  ct1_words[8];
  logic [31:0]  ct2_words[8];
  enc_vec_t     vecs[3];

  smaesh_word_bridge_if #(.d(D)) bus();
  smaesh_word_bridge #(.d(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Scoreboard side: every accepted output word must match the head of the queue.
  always begin
    @(negedge clk);
    #2;
    if (!rst && bus.out_word_valid && bus.out_word_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL ow_unexpected: got word %h expected no word", bus.out_word);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("ow_word", {224'd0, bus.out_word}, {224'd0, mon_exp});
        chk("ct_ready_busy", {255'd0, bus.core_ct_ready}, 256'd0);
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int k = 0;
    bus.in_word_valid = 1'b1;
    bus.in_word       = w;
    while (!bus.in_word_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("send_timeout", 256'd1, 256'd0);
    @(negedge clk);
    bus.in_word_valid = 1'b0;
  endtask

  task automatic run_enc(input logic [31:0] hdr, input logic [31:0] base,
                         input logic [31:0] stride, input int nkey, input string nm);
    logic [255:0] ep, ek;
    logic [31:0]  w;
    int nw;
    ep = '0;
    ek = last_key;
    nw = 8 + nkey;
    send_word(hdr);
    for (int i = 0; i < nw; i++) begin
      w = base + 32'(i) * stride;
      if (i < 8) ep[32*i +: 32] = w;
      else       ek[32*(i-8) +: 32] = w;
      if (i == nw - 1) chk({nm, "_valid_early"}, {255'd0, bus.core_in_valid}, 256'd0);
      send_word(w);
    end
    chk({nm, "_valid"}, {255'd0, bus.core_in_valid}, 256'd1);
    chk({nm, "_seed_valid"}, {255'd0, bus.core_seed_valid}, 256'd0);
    chk({nm, "_in_ready"}, {255'd0, bus.in_word_ready}, 256'd0);
    chk({nm, "_pt"}, bus.core_plaintext, ep);
    chk({nm, "_key"}, bus.core_key, ek);
    repeat (2) @(negedge clk);
    chk({nm, "_valid_hold"}, {255'd0, bus.core_in_valid}, 256'd1);
    chk({nm, "_pt_hold"}, bus.core_plaintext, ep);
    bus.core_in_ready = 1'b1;
    @(negedge clk);
    bus.core_in_ready = 1'b0;
    chk({nm, "_valid_drop"}, {255'd0, bus.core_in_valid}, 256'd0);
    chk({nm, "_back_hdr"}, {255'd0, bus.in_word_ready}, 256'd1);
    last_key = ek;
  endtask

  task automatic run_reseed();
    send_word(32'h0000_0001);
    send_word(32'hAAAA_AAAA);
    send_word(32'h5555_5555);
    chk("seed_valid_early", {255'd0, bus.core_seed_valid}, 256'd0);
    send_word(32'hFFFF_1234);
    chk("seed_valid", {255'd0, bus.core_seed_valid}, 256'd1);
    chk("seed_value", {176'd0, bus.core_seed}, {176'd0, 80'h1234_55555555_AAAAAAAA});
    chk("seed_no_core_in", {255'd0, bus.core_in_valid}, 256'd0);
    repeat (2) @(negedge clk);
    chk("seed_valid_hold", {255'd0, bus.core_seed_valid}, 256'd1);
    chk("seed_no_core_in_hold", {255'd0, bus.core_in_valid}, 256'd0);
    bus.core_seed_ready = 1'b1;
    @(negedge clk);
    bus.core_seed_ready = 1'b0;
    chk("seed_valid_drop", {255'd0, bus.core_seed_valid}, 256'd0);
    chk("seed_no_core_in_end", {255'd0, bus.core_in_valid}, 256'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{hdr: 32'hFFFF_FFF8, base: 32'hA5A5_0000, stride: 32'h0101_0101};
    vecs[1] = '{hdr: 32'h0000_0010, base: 32'hFFFF_FFF0, stride: 32'hFFFF_FFFF};
    vecs[2] = '{hdr: 32'h8000_0000, base: 32'h1357_9BDF, stride: 32'h1000_0001};
    ct1_words = '{32'hCAFEF00D, 32'hDEADBEEF, 32'hCCDDEEFF, 32'h8899AABB,
                  32'h44556677, 32'h00112233, 32'h89ABCDEF, 32'h01234567};
    ct2_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                  32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    last_key = '0;

    rst = 1'b1;
    bus.in_word_valid   = 1'b0;
    bus.in_word         = '0;
    bus.out_word_ready  = 1'b0;
    bus.core_in_ready   = 1'b0;
    bus.core_seed_ready = 1'b0;
    bus.core_ct_valid   = 1'b0;
    bus.core_ct         = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {255'd0, bus.in_word_ready}, 256'd0);
    chk("rst_out_valid", {255'd0, bus.out_word_valid}, 256'd0);
    chk("rst_core_in_valid", {255'd0, bus.core_in_valid}, 256'd0);
    chk("rst_seed_valid", {255'd0, bus.core_seed_valid}, 256'd0);
    chk("rst_err", {255'd0, bus.err}, 256'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {255'd0, bus.in_word_ready}, 256'd1);
    chk("idle_ct_ready", {255'd0, bus.core_ct_ready}, 256'd1);

    // Plain counting encrypt, with the exact bus images written out.
    run_enc(32'h0, 32'h0, 32'h1, 8, "enc0");
    chk("enc0_pt_const", bus.core_plaintext,
        256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
    chk("enc0_key_const", bus.core_key,
        256'h0000000F_0000000E_0000000D_0000000C_0000000B_0000000A_00000009_00000008);

    for (int v = 0; v < 3; v++) run_enc(vecs[v].hdr, vecs[v].base, vecs[v].stride, 8, "enc_tab");

    // Invalid opcode: header swallowed, single err pulse, next header still taken.
    send_word(32'h0000_0003);
    chk("inv_err", {255'd0, bus.err}, 256'd1);
    chk("inv_in_ready", {255'd0, bus.in_word_ready}, 256'd1);
    chk("inv_no_core_in", {255'd0, bus.core_in_valid}, 256'd0);
    @(negedge clk);
    chk("inv_err_drop", {255'd0, bus.err}, 256'd0);
    run_enc(32'h0000_0020, 32'h0BAD_0000, 32'h3, 8, "after_inv");

`ifdef SMAESH_KEY_CACHE_EN
    run_enc(32'h0000_0004, 32'h0000_0040, 32'h3, 0, "key_cache");
`else
    run_enc(32'h0000_0004, 32'h0000_0040, 32'h3, 8, "key_cache");
`endif

    // Ciphertext streamed with toggling ready while a reseed loads in parallel.
    chk("ct1_ready_before", {255'd0, bus.core_ct_ready}, 256'd1);
    bus.core_ct       = CT1;
    bus.core_ct_valid = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(ct1_words[i]);
    @(negedge clk);
    bus.core_ct_valid = 1'b0;
    chk("ct1_ready_full", {255'd0, bus.core_ct_ready}, 256'd0);
    chk("ct1_out_valid", {255'd0, bus.out_word_valid}, 256'd1);
    fork
      begin
        int kk = 0;
        while (exp_q.size() != 0 && kk < 100) begin
          @(negedge clk);
          bus.out_word_ready = ~bus.out_word_ready;
          kk++;
        end
        if (kk >= 100) chk("ct1_drain_timeout", 256'd1, 256'd0);
      end
      run_reseed();
    join
    chk("ct1_out_idle", {255'd0, bus.out_word_valid}, 256'd0);
    chk("ct1_ready_idle", {255'd0, bus.core_ct_ready}, 256'd1);

    // Back-to-back blocks: the buffer must sit empty one cycle before refilling.
    @(negedge clk);
    bus.out_word_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) exp_q.push_back(ct2_words[i]);
    bus.core_ct       = CT2;
    bus.core_ct_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      #3;
      k++;
    end while (exp_q.size() > 8 && k < 40);
    if (k >= 40) chk("ct2_first_timeout", 256'd1, 256'd0);
    @(negedge clk);
    chk("ct2_gap_out_valid", {255'd0, bus.out_word_valid}, 256'd0);
    chk("ct2_gap_ct_ready", {255'd0, bus.core_ct_ready}, 256'd1);
    @(negedge clk);
    chk("ct2_refill_out_valid", {255'd0, bus.out_word_valid}, 256'd1);
    bus.core_ct_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      #3;
      k++;
    end while (exp_q.size() != 0 && k < 40);
    if (k >= 40) chk("ct2_second_timeout", 256'd1, 256'd0);
    @(negedge clk);
    chk("ct2_out_idle", {255'd0, bus.out_word_valid}, 256'd0);

    // Reset in the middle of a plaintext load with a ciphertext block still buffered.
    bus.out_word_ready = 1'b0;
    bus.core_ct       = CT1;
    bus.core_ct_valid = 1'b1;
    @(negedge clk);
    bus.core_ct_valid = 1'b0;
    chk("mid_ct_buffered", {255'd0, bus.out_word_valid}, 256'd1);
    send_word(32'h0);
    for (int i = 0; i < 5; i++) send_word(32'hDEAD_0000 + 32'(i));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_in_ready", {255'd0, bus.in_word_ready}, 256'd0);
    chk("mid_rst_out_valid", {255'd0, bus.out_word_valid}, 256'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {255'd0, bus.in_word_ready}, 256'd1);
    chk("post_rst_out_valid", {255'd0, bus.out_word_valid}, 256'd0);
    chk("post_rst_ct_ready", {255'd0, bus.core_ct_ready}, 256'd1);
    chk("post_rst_core_in", {255'd0, bus.core_in_valid}, 256'd0);
    bus.out_word_ready = 1'b1;
    run_enc(32'h0, 32'h0000_0100, 32'h1, 8, "post_rst");
    repeat (3) @(negedge clk);
    chk("sb_empty", {224'd0, 32'(exp_q.size())}, 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/smaesh_word_bridge.md
SMAESH_WORD_BRIDGE -- requirements
Module: smaesh_word_bridge

Interface
REQ-001 Parameter d, default 2: number of masking shares; 128*d bits per shared block.
REQ-002 clk  in  1  clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_word_valid / in_word_ready / in_word  in/out/in  1/1/32  host command word stream.
REQ-005 out_word_valid / out_word_ready / out_word  out/in/out  1/1/32  host ciphertext word stream.
REQ-006 core_in_valid / core_in_ready  out/in  1/1  block handshake toward the masked encryption core.
REQ-007 core_plaintext / core_key  out  128*d each  share-major buses; share j at bits [128j +: 128].
REQ-008 core_seed_valid / core_seed_ready / core_seed  out/in/out  1/1/80  PRNG reseed handshake; ready is a one-cycle pulse.
REQ-009 core_ct_valid / core_ct_ready / core_ct  in/out/in  1/1/128*d  ciphertext from the core.
REQ-010 err  out  1  one-cycle pulse on an unknown opcode.

Function
REQ-011 Header word: bits[1:0] opcode (0 encrypt, 1 reseed, 2-3 invalid); bit[2] reuse_key; other bits ignored.
REQ-012 Encrypt: the header is followed by 4d plaintext words, then 4d key words; word i fills bits [32i +: 32].
REQ-013 Reseed: the header is followed by 3 words: seed[31:0], seed[63:32], then seed[79:64] taken from word[15:0].
REQ-014 FSM states: HDR, LD_PT, LD_KEY, LD_SEED, ISSUE, ISSUE_SEED; a word counter of clog2(4d) bits wraps to 0 on each state change.
REQ-015 in_word_ready is 1 only in HDR, LD_PT, LD_KEY and LD_SEED; a word transfers when valid and ready are both 1.
REQ-016 In ISSUE, core_in_valid is 1 on the cycle after the last load word is accepted and stays 1 until core_in_ready; the FSM then returns to HDR.
REQ-017 In ISSUE_SEED, core_seed_valid stays 1 until the core_seed_ready pulse; the FSM then returns to HDR.
REQ-018 core_in_valid and core_seed_valid are never 1 in the same cycle.
REQ-019 On an invalid opcode, the header is consumed, err pulses in the next cycle, and the FSM stays in HDR.
REQ-020 core_plaintext, core_key and core_seed hold stable while the matching valid is 1.
REQ-021 Output buffer: core_ct_ready = ~obuf_full; on capture, obuf_full is set and core_ct is latched.
REQ-022 Words 0..4d-1 stream on out_word in order; obuf_full clears when the last word is accepted.
REQ-023 The output path runs independently of the input FSM; loading the next command may overlap ciphertext streaming.
REQ-024 A new capture may not occur in the same cycle that the last word leaves; the buffer must be empty for one cycle first.

Reset
REQ-025 Under rst: FSM to HDR, counters to 0, obuf_full to 0.
REQ-026 Under rst: all valid outputs, in_word_ready and err are 0.
REQ-027 Data registers are not reset.
REQ-028 A reset mid-command discards partial loads and any buffered ciphertext.

Configuration
REQ-029 Macro SMAESH_KEY_CACHE_EN, when defined: on encrypt with reuse_key=1, LD_KEY is skipped and the FSM goes LD_PT -> ISSUE using the held key register.
REQ-030 When SMAESH_KEY_CACHE_EN is undefined: reuse_key is ignored and LD_KEY is always executed.

Structure
REQ-031 A shared package holds the opcode constants, the FSM state encoding and the header bit positions.
REQ-032 Sub-module smaesh_word_ser, parameterised by word count, implements the output buffer and serializer.

Verification
REQ-033 d=2, reset, then encrypt header 0x0 followed by 16 words 0x00000000..0x0000000F: core_plaintext word i = i, core_key word i = 8+i, core_in_valid rises exactly 1 cycle after word 16.
REQ-034 Reseed header 0x1, then 0xAAAAAAAA, 0x55555555, 0xFFFF1234: core_seed = 0x1234_55555555_AAAAAAAA; valid drops after the ready pulse; core_in_valid stays 0 throughout.
REQ-035 With core_ct = 256'h0123... and out_word_ready toggling every cycle: 8 words emerge in order; core_ct_ready is 0 while the words stream.
REQ-036 With SMAESH_KEY_CACHE_EN defined, header 0x4 followed by 8 words: ISSUE is reached after 8 words and core_key is unchanged; with the macro undefined, 16 words are required.
REQ-037 Header 0x3: err pulses once, in_word_ready stays 1, and the next valid header is accepted.
REQ-038 rst asserted after 5 plaintext words: after release, in HDR, the next header restarts loading at word 0 and out_word_valid is 0.
